addsub_sequencer: RTL and testbench

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_sequencer.sv | 87 ++++++++
 tb/tb_addsub_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: sequences an A op B op C op D add/subtract datapath; ADDSUB_SEQUENCER_ABORT_EN enables the abort input
module addsub_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       abort,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       addOrSub,
  output logic       done,
  output logic       busy,
  output logic       result_valid
);
  typedef enum logic [2:0] {IDLE, LOAD, STEP_B, STEP_C, STEP_D, FINISH} state_t;
  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
  state_t     r_state, w_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_op;
  logic       r_s0, r_s1, r_s2, r_add, r_done, r_busy, r_rv;
  logic       w_abort;
`ifdef ADDSUB_SEQUENCER_ABORT_EN
  assign w_abort = abort && r_state != IDLE;
`else
  logic w_unused_abort;
  assign w_unused_abort = abort;
  assign w_abort = 1'b0;
`endif
  // next state and hold counter; abort overrides any same-cycle advance
  always_comb begin
    w_nxt = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: if (start) begin
        w_nxt = LOAD;
        w_cnt_nxt = HOLD_M1;
      end
      LOAD, STEP_B, STEP_C, STEP_D: if (r_cnt == 4'd0) begin
        w_nxt = r_state == LOAD ? STEP_B : r_state == STEP_B ? STEP_C : r_state == STEP_C ? STEP_D : FINISH;
        w_cnt_nxt = HOLD_M1;
      end else w_cnt_nxt = r_cnt - 4'd1;
      default: begin
        w_nxt = IDLE;
        w_cnt_nxt = 4'd0;
      end
    endcase
    if (w_abort) begin
      w_nxt = IDLE;
      w_cnt_nxt = 4'd0;
    end
  end
  // state register with outputs decoded from the next state so they are all registered
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      r_op <= 3'b111;
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_add <= 1'b1;
      r_done <= 1'b1;
      r_busy <= 1'b0;
      r_rv <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_cnt_nxt;
      if (r_state == IDLE && start) r_op <= op;
      r_s0 <= !(w_nxt == IDLE || w_nxt == LOAD);
      r_s1 <= w_nxt == STEP_C;
      r_s2 <= w_nxt == STEP_D || w_nxt == FINISH;
      r_add <= w_nxt == STEP_B ? r_op[0] : w_nxt == STEP_C ? r_op[1] : (w_nxt == STEP_D || w_nxt == FINISH) ? r_op[2] : 1'b1;
      r_done <= w_nxt == IDLE || w_nxt == FINISH;
      r_busy <= w_nxt != IDLE;
      r_rv <= w_nxt == FINISH;
    end
  assign s0 = r_s0;
  assign s1 = r_s1;
  assign s2 = r_s2;
  assign addOrSub = r_add;
  assign done = r_done;
  assign busy = r_busy;
  assign result_valid = r_rv;
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: checks HOLD_CYCLES=1 and HOLD_CYCLES=3 sequencers against a cycle-position model
module tb_addsub_sequencer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [2:0] op = 3'b000;
  logic s0_1, s1_1, s2_1, as_1, dn_1, bz_1, rv_1;
  logic s0_3, s1_3, s2_3, as_3, dn_3, bz_3, rv_3;
  int n_cmp = 0, n_bad = 0;
  int hold [2] = '{1, 3};
  bit act [2] = '{0, 0};
  int pos [2] = '{0, 0};
  logic [2:0] opc [2] = '{3'b111, 3'b111};
`ifdef ADDSUB_SEQUENCER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  addsub_sequencer #(.HOLD_CYCLES(1)) u_h1 (.clock(clock), .reset(reset), .start(start), .op(op), .abort(abort),
    .s0(s0_1), .s1(s1_1), .s2(s2_1), .addOrSub(as_1), .done(dn_1), .busy(bz_1), .result_valid(rv_1));
  addsub_sequencer #(.HOLD_CYCLES(3)) u_h3 (.clock(clock), .reset(reset), .start(start), .op(op), .abort(abort),
    .s0(s0_3), .s1(s1_3), .s2(s2_3), .addOrSub(as_3), .done(dn_3), .busy(bz_3), .result_valid(rv_3));

  always #5 clock = ~clock;

  // expected {s0,s2,s1,addOrSub,done,busy,result_valid} at cycle position p of a sequence (p=1 is first LOAD cycle)
  function automatic logic [6:0] expect_out(int h, bit a, int p, logic [2:0] o);
    int ph;
    if (!a) return 7'b0001100;
    if (p == 4 * h + 1) return {3'b110, o[2], 3'b111};
    ph = (p - 1) / h;
    case (ph)
      0: return 7'b0001010;
      1: return {3'b100, o[0], 3'b010};
      2: return {3'b101, o[1], 3'b010};
      default: return {3'b110, o[2], 3'b010};
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++)
      if (act[i]) begin
        if ((ABORT_EN && abort) || pos[i] == 4 * hold[i] + 1) act[i] = 1'b0;
        else pos[i]++;
      end else if (start) begin
        act[i] = 1'b1;
        pos[i] = 1;
        opc[i] = op;
      end
  endtask

  task automatic check(string tag, logic [6:0] obs, logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    check({tag, "_h1"}, {s0_1, s2_1, s1_1, as_1, dn_1, bz_1, rv_1}, expect_out(1, act[0], pos[0], opc[0]));
    check({tag, "_h3"}, {s0_3, s2_3, s1_3, as_3, dn_3, bz_3, rv_3}, expect_out(3, act[1], pos[1], opc[1]));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all("cycle");
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    act[0] = 1'b0;
    act[1] = 1'b0;
    compare_all("async_reset");
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat1, lat3, nrv, last;
    repeat (2) @(posedge clock);
    #1;
    compare_all("reset");
    #2;
    reset = 1'b0;
    op = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    lat1 = 0;
    lat3 = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      if (rv_1 && lat1 == 0) lat1 = k;
      if (rv_3 && lat3 == 0) lat3 = k;
    end
    check_int("latency_h1", lat1, 5);
    check_int("latency_h3", lat3, 13);
    op = 3'b010;
    start = 1'b1;
    step();
    start = 1'b0;
    steps(16);
    op = 3'b101;
    start = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    op = 3'b000;
    start = 1'b1;
    step();
    start = 1'b0;
    steps(16);
    op = 3'b110;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    async_reset();
    steps(2);
    op = 3'b011;
    start = 1'b1;
    step();
    start = 1'b0;
    steps(16);
    op = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    steps(16);
    op = 3'b001;
    start = 1'b1;
    nrv = 0;
    last = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (rv_1) begin
        nrv++;
        last = k;
      end
    end
    start = 1'b0;
    check_int("b2b_rv_count", nrv, 3);
    check_int("b2b_last_rv", last, 17);
    steps(16);
    for (int k = 0; k < 400; k++) begin
      start = $urandom_range(0, 2) == 0;
      op = 3'($urandom);
      abort = $urandom_range(0, 15) == 0;
      step();
      if ($urandom_range(0, 49) == 0) async_reset();
    end
    start = 1'b0;
    abort = 1'b0;
    steps(16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
